param_loader: RTL and testbench

PARAM_LOADER -- requirements
Module: param_loader

---
 rtl/param_loader.sv | 117 +++++++++++
 tb/tb_param_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_loader.sv
// Byte-serial loader for per-channel amplitude, offset and phase-increment words.
// Frames stage into a shadow bank; a commit header publishes all 48 words at once.
module param_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [255:0] amps,
    output logic [255:0] offsets,
    output logic [255:0] phasewords,
    output logic         ack,
    output logic         err,
    output logic         busy
);
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_WRITE} state_e;
    typedef enum logic [1:0] {
        F_AMP    = 2'b00,
        F_OFFSET = 2'b01,
        F_PHASE  = 2'b10,
        F_COMMIT = 2'b11
    } field_e;

    // The timeout fires on the edge that would bring the idle count to TIMEOUT,
    // so a byte arriving at count TIMEOUT-1 still wins.
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_e      state;
    field_e      field;
    logic [3:0]  channel;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic [7:0]  idle_cnt;
    logic [15:0] shadow [3][16];
    logic        xfer;
    field_e      hdr_field;

    assign rx_ready  = (state != S_WRITE);
    assign busy      = (state != S_IDLE);
    assign xfer      = rx_valid && rx_ready;
    assign hdr_field = field_e'(rx_data[7:6]);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            field      <= F_AMP;
            channel    <= '0;
            hi_byte    <= '0;
            lo_byte    <= '0;
            idle_cnt   <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            amps       <= '0;
            offsets    <= '0;
            phasewords <= '0;
            // NOTE: the shadow bank is cleared on reset so a commit straight after
            // reset publishes zeros rather than stale staged values.
            for (int f = 0; f < 3; f++) begin
                for (int c = 0; c < 16; c++) begin
                    shadow[f][c] <= '0;
                end
            end
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    idle_cnt <= '0;
                    if (xfer) begin
                        if (rx_data[5:4] != 2'b00) begin
                            err <= 1'b1;
                        end else if (hdr_field == F_COMMIT) begin
                            ack <= 1'b1;
                            for (int c = 0; c < 16; c++) begin
                                amps[16*c +: 16]       <= shadow[0][c];
                                offsets[16*c +: 16]    <= shadow[1][c];
                                phasewords[16*c +: 16] <= shadow[2][c];
                            end
                        end else begin
                            field   <= hdr_field;
                            channel <= rx_data[3:0];
                            state   <= S_HI;
                        end
                    end
                end
                S_HI, S_LO: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (state == S_HI) begin
                            hi_byte <= rx_data;
                            state   <= S_LO;
                        end else begin
                            lo_byte <= rx_data;
                            ack     <= 1'b1;
                            state   <= S_WRITE;
                        end
                    end else if (idle_cnt >= IDLE_LIMIT) begin
                        idle_cnt <= '0;
                        err      <= 1'b1;
                        state    <= S_IDLE;
                    end else if (idle_cnt != 8'hFF) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    shadow[field][channel] <= {hi_byte, lo_byte};
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: staging, commit, reserved headers,
// interbyte timeout, reset mid-frame and back-to-back streaming.
module tb_param_loader;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [255:0] amps;
    logic [255:0] offsets;
    logic [255:0] phasewords;
    logic         ack;
    logic         err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int ready_low_cnt = 0;
    bit stream_on = 1'b0;

    param_loader #(.TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .amps       (amps),
        .offsets    (offsets),
        .phasewords (phasewords),
        .ack        (ack),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if (err) err_cnt++;
        if (ack && err) both_cnt++;
        if (stream_on && !rx_ready) ready_low_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte with rx_valid high and return just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int waited;
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            acc = rx_ready;
            tick();
            waited++;
        end while (!acc && waited < 10);
        if (!acc) check("send_accept", 0, 1);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    int a0, e0;

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_ready", rx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ack_err", {ack, err}, 0);
        check("rst_outputs", amps | offsets | phasewords, 0);

        // Write amp ch3 = 0x1234, then commit
        tick();
        a0 = ack_cnt;
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        rx_valid = 1'b0;
        @(negedge clk);
        check("write_ack", ack, 1);
        check("write_ready_low", rx_ready, 0);
        check("amps_before_commit", amps, 0);
        tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("commit_ack", ack, 1);
        check("commit_amps", amps, 256'h1234 << 48);
        check("commit_others", offsets | phasewords, 0);
        tick();
        check("ack_count_wc", ack_cnt - a0, 2);

        // Staging isolation
        do_reset();
        send_byte(8'h8F); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h40); send_byte(8'h80); send_byte(8'h00);
        rx_valid = 1'b0;
        tick();
        @(negedge clk);
        check("stage_no_publish", amps | offsets | phasewords, 0);
        tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("stage_phase", phasewords, 256'hFFFF << 240);
        check("stage_offset", offsets, 256'h8000);
        tick();

        // Reserved-bit header
        e0 = err_cnt;
        send_byte(8'h23);
        rx_valid = 1'b0;
        @(negedge clk);
        check("rsvd_err", err, 1);
        check("rsvd_busy", busy, 0);
        tick();
        send_byte(8'h00);
        rx_valid = 1'b0;
        @(negedge clk);
        check("rsvd_next_header", busy, 1);
        tick();
        send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        tick();
        check("rsvd_err_count", err_cnt - e0, 1);

        // Timeout: 255 idle cycles in LO
        send_byte(8'h81);
        send_byte(8'hAA);
        rx_valid = 1'b0;
        repeat (254) tick();
        @(negedge clk);
        check("to_not_yet", {busy, err}, 2'b10);
        tick();
        @(negedge clk);
        check("to_fire", {busy, err}, 2'b01);
        tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("to_discarded", phasewords, 256'hFFFF << 240);
        tick();

        // Byte at idle count 254 still completes
        send_byte(8'h81);
        send_byte(8'hAA);
        rx_valid = 1'b0;
        repeat (254) tick();
        send_byte(8'h55);
        rx_valid = 1'b0;
        @(negedge clk);
        check("to_edge_ack", {ack, err}, 2'b10);
        tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("to_edge_word", phasewords, (256'hFFFF << 240) | (256'hAA55 << 16));
        tick();

        // Reset mid-frame after the HI byte
        send_byte(8'h45);
        send_byte(8'h77);
        a0 = ack_cnt;
        e0 = err_cnt;
        do_reset();
        @(negedge clk);
        check("rst_mid_pulses", (ack_cnt - a0) + (err_cnt - e0), 0);
        check("rst_mid_state", {busy, rx_ready}, 2'b01);
        tick();
        send_byte(8'hC0);
        rx_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_offsets", offsets, 0);
        tick();

        // Back-to-back streaming with rx_valid held high
        a0 = ack_cnt;
        stream_on = 1'b1;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h42); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h83); send_byte(8'h7F); send_byte(8'hFF);
        send_byte(8'hC0);
        stream_on = 1'b0;
        rx_valid = 1'b0;
        tick();
        check("stream_ready_low", ready_low_cnt, 3);
        check("stream_acks", ack_cnt - a0, 4);
        check("stream_amps", amps, 256'h0102 << 16);
        check("stream_offsets", offsets, 256'hBEEF << 32);
        check("stream_phase", phasewords, 256'h7FFF << 48);

        check("ack_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
